mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (CPU / DMNI) arbiter in front of a single-port
//               synchronous memory. Combinational grant with a saturating
//               burst counter for fairness, and a registered read-owner tag
//               that steers the one-cycle-late read response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // CPU port
    input  logic                  cpu_req_i,
    input  logic [3:0]            cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [31:0]           cpu_rdata_o,
    // DMNI port
    input  logic                  dma_req_i,
    input  logic [3:0]            dma_we_i,
    input  logic [ADDR_WIDTH-1:0] dma_addr_i,
    input  logic [31:0]           dma_data_i,
    output logic                  dma_gnt_o,
    output logic                  dma_rvalid_o,
    output logic [31:0]           dma_rdata_o,
    // Memory port
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    owner_e     r_owner;
    owner_e     w_owner_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_burst_done;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic       r_cpu_rd_pend;
    logic       r_dma_rd_pend;

    // The current owner has used up its burst allowance once cnt reaches the limit.
    assign w_burst_done = (r_cnt >= C_MAX_BURST);

    // Grant decision: a lone requester always wins; contention follows the owner/burst rule.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (cpu_req_i && !dma_req_i) begin
            w_cpu_gnt = 1'b1;
        end else if (!cpu_req_i && dma_req_i) begin
            w_dma_gnt = 1'b1;
        end else if (cpu_req_i && dma_req_i) begin
            case (r_owner)
                OWN_CPU: begin
                    w_cpu_gnt = !w_burst_done;
                    w_dma_gnt =  w_burst_done;
                end
                OWN_DMA: begin
                    w_dma_gnt = !w_burst_done;
                    w_cpu_gnt =  w_burst_done;
                end
                default: begin
                    w_cpu_gnt = 1'b1;
                end
            endcase
        end
    end

    // Owner / burst counter next state: continue, switch or fall back to idle.
    always_comb begin
        w_owner_next = OWN_NONE;
        w_cnt_next   = 8'd0;
        if (w_cpu_gnt) begin
            w_owner_next = OWN_CPU;
            if (r_owner == OWN_CPU) begin
                w_cnt_next = w_burst_done ? C_MAX_BURST : (r_cnt + 8'd1);
            end else begin
                w_cnt_next = 8'd1;
            end
        end else if (w_dma_gnt) begin
            w_owner_next = OWN_DMA;
            if (r_owner == OWN_DMA) begin
                w_cnt_next = w_burst_done ? C_MAX_BURST : (r_cnt + 8'd1);
            end else begin
                w_cnt_next = 8'd1;
            end
        end
    end

    // Owner and burst counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWN_NONE;
            r_cnt   <= 8'd0;
        end else begin
            r_owner <= w_owner_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Read tags captured at issue so a later owner switch cannot redirect the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cpu_rd_pend <= 1'b0;
            r_dma_rd_pend <= 1'b0;
        end else begin
            r_cpu_rd_pend <= w_cpu_gnt && (cpu_we_i == 4'b0000);
            r_dma_rd_pend <= w_dma_gnt && (dma_we_i == 4'b0000);
        end
    end

    // Memory request mux: granted port drives the memory, everything zero when idle.
    always_comb begin
        mem_we_o   = 4'b0000;
        mem_addr_o = '0;
        mem_data_o = 32'd0;
        if (w_cpu_gnt) begin
            mem_we_o   = cpu_we_i;
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
        end else if (w_dma_gnt) begin
            mem_we_o   = dma_we_i;
            mem_addr_o = dma_addr_i;
            mem_data_o = dma_data_i;
        end
    end

    assign mem_en_o     = w_cpu_gnt | w_dma_gnt;
    assign cpu_gnt_o    = w_cpu_gnt;
    assign dma_gnt_o    = w_dma_gnt;
    assign cpu_rvalid_o = r_cpu_rd_pend;
    assign dma_rvalid_o = r_dma_rd_pend;
    assign cpu_rdata_o  = mem_data_i;
    assign dma_rdata_o  = mem_data_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven bench for mem_port_arbiter with
//               hand-written sequences for burst fairness, saturation and
//               reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        cpu_req_i;
    logic [3:0]  cpu_we_i;
    logic [23:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_gnt_o;
    logic        cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        dma_req_i;
    logic [3:0]  dma_we_i;
    logic [23:0] dma_addr_i;
    logic [31:0] dma_data_i;
    logic        dma_gnt_o;
    logic        dma_rvalid_o;
    logic [31:0] dma_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [23:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH (24),
        .MAX_BURST  (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .dma_req_i    (dma_req_i),
        .dma_we_i     (dma_we_i),
        .dma_addr_i   (dma_addr_i),
        .dma_data_i   (dma_data_i),
        .dma_gnt_o    (dma_gnt_o),
        .dma_rvalid_o (dma_rvalid_o),
        .dma_rdata_o  (dma_rdata_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        cpu_req;
        logic [3:0]  cpu_we;
        logic [23:0] cpu_addr;
        logic [31:0] cpu_data;
        logic        dma_req;
        logic [3:0]  dma_we;
        logic [23:0] dma_addr;
        logic [31:0] dma_data;
        logic [31:0] mem_rdata;
        logic        e_cpu_gnt;
        logic        e_dma_gnt;
        logic [3:0]  e_we;
        logic [23:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_cpu_rv;
        logic        e_dma_rv;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic [3:0] cwe, input logic [23:0] caddr,
                         input logic [31:0] cdata, input logic dreq, input logic [3:0] dwe,
                         input logic [23:0] daddr, input logic [31:0] ddata, input logic [31:0] mrd);
        cpu_req_i  = creq;  cpu_we_i = cwe; cpu_addr_i = caddr; cpu_data_i = cdata;
        dma_req_i  = dreq;  dma_we_i = dwe; dma_addr_i = daddr; dma_data_i = ddata;
        mem_data_i = mrd;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
        drive(0, 4'h0, 24'h0, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);
    endtask

    initial begin
        // {cpu req,we,addr,data | dma req,we,addr,data | mem rdata | exp cgnt,dgnt,we,addr,wdata,crv,drv}
        vecs[0]  = '{0,4'h0,24'h000000,32'h00000000, 0,4'h0,24'h000000,32'h00000000, 32'h00000000, 0,0,4'h0,24'h000000,32'h00000000, 0,0};
        vecs[1]  = '{1,4'h0,24'h000100,32'hAAAA0001, 0,4'h0,24'h000000,32'h00000000, 32'h00000000, 1,0,4'h0,24'h000100,32'hAAAA0001, 0,0};
        vecs[2]  = '{0,4'h0,24'h000000,32'h00000000, 0,4'h0,24'h000000,32'h00000000, 32'hDEADBEEF, 0,0,4'h0,24'h000000,32'h00000000, 1,0};
        vecs[3]  = '{0,4'h0,24'h000000,32'h00000000, 1,4'hF,24'h000040,32'h12345678, 32'h00000000, 0,1,4'hF,24'h000040,32'h12345678, 0,0};
        vecs[4]  = '{0,4'h0,24'h000000,32'h00000000, 0,4'h0,24'h000000,32'h00000000, 32'h55555555, 0,0,4'h0,24'h000000,32'h00000000, 0,0};
        vecs[5]  = '{1,4'h0,24'h000010,32'h00000000, 0,4'h0,24'h000000,32'h00000000, 32'h00000000, 1,0,4'h0,24'h000010,32'h00000000, 0,0};
        vecs[6]  = '{0,4'h0,24'h000000,32'h00000000, 1,4'h0,24'h000020,32'hBBBB0002, 32'h11111111, 0,1,4'h0,24'h000020,32'hBBBB0002, 1,0};
        vecs[7]  = '{0,4'h0,24'h000000,32'h00000000, 0,4'h0,24'h000000,32'h00000000, 32'h22222222, 0,0,4'h0,24'h000000,32'h00000000, 0,1};
        vecs[8]  = '{1,4'h3,24'h000300,32'hC0C0C0C0, 1,4'hC,24'h000400,32'hD0D0D0D0, 32'h00000000, 1,0,4'h3,24'h000300,32'hC0C0C0C0, 0,0};
        vecs[9]  = '{1,4'h1,24'h000304,32'hC1C1C1C1, 1,4'hC,24'h000404,32'hD1D1D1D1, 32'h00000000, 1,0,4'h1,24'h000304,32'hC1C1C1C1, 0,0};
        vecs[10] = '{0,4'hF,24'hFFFFFF,32'hFFFFFFFF, 0,4'hF,24'hABCDEF,32'hFFFFFFFF, 32'h00000000, 0,0,4'h0,24'h000000,32'h00000000, 0,0};
        vecs[11] = '{0,4'hF,24'h111111,32'h99999999, 1,4'h2,24'h000500,32'hE0E0E0E0, 32'h00000000, 0,1,4'h2,24'h000500,32'hE0E0E0E0, 0,0};
        vecs[12] = '{1,4'h1,24'h000600,32'h00000001, 1,4'h4,24'h000504,32'hE1E1E1E1, 32'h00000000, 0,1,4'h4,24'h000504,32'hE1E1E1E1, 0,0};

        // Reset state, and combinational grant while reset is held
        rst_ni = 1'b0;
        drive(0, 4'h0, 24'h0, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);
        #1;
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
        chk("rst_dma_rvalid", {31'd0, dma_rvalid_o}, 32'd0);
        chk("rst_mem_en",     {31'd0, mem_en_o},     32'd0);
        chk("rst_mem_addr",   {8'd0, mem_addr_o},    32'd0);
        drive(1, 4'h0, 24'h000777, 32'h0, 1, 4'h0, 24'h000888, 32'h0, 32'h0);
        #1;
        chk("rst_both_cpu_gnt", {31'd0, cpu_gnt_o}, 32'd1);
        chk("rst_both_dma_gnt", {31'd0, dma_gnt_o}, 32'd0);
        chk("rst_both_addr",    {8'd0, mem_addr_o}, 32'h000777);
        drive(0, 4'h0, 24'h0, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Table-driven single-cycle vectors
        for (int v = 0; v < NVEC; v++) begin
            @(posedge clk_i); #1;
            drive(vecs[v].cpu_req, vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_data,
                  vecs[v].dma_req, vecs[v].dma_we, vecs[v].dma_addr, vecs[v].dma_data,
                  vecs[v].mem_rdata);
            @(negedge clk_i);
            chk($sformatf("v%0d_cpu_gnt", v), {31'd0, cpu_gnt_o}, {31'd0, vecs[v].e_cpu_gnt});
            chk($sformatf("v%0d_dma_gnt", v), {31'd0, dma_gnt_o}, {31'd0, vecs[v].e_dma_gnt});
            chk($sformatf("v%0d_mem_en", v),  {31'd0, mem_en_o},
                {31'd0, vecs[v].e_cpu_gnt | vecs[v].e_dma_gnt});
            chk($sformatf("v%0d_mem_we", v),   {28'd0, mem_we_o},  {28'd0, vecs[v].e_we});
            chk($sformatf("v%0d_mem_addr", v), {8'd0, mem_addr_o}, {8'd0, vecs[v].e_addr});
            chk($sformatf("v%0d_mem_data", v), mem_data_o, vecs[v].e_wdata);
            chk($sformatf("v%0d_cpu_rvalid", v), {31'd0, cpu_rvalid_o}, {31'd0, vecs[v].e_cpu_rv});
            chk($sformatf("v%0d_dma_rvalid", v), {31'd0, dma_rvalid_o}, {31'd0, vecs[v].e_dma_rv});
            if (vecs[v].e_cpu_rv) chk($sformatf("v%0d_cpu_rdata", v), cpu_rdata_o, vecs[v].mem_rdata);
            if (vecs[v].e_dma_rv) chk($sformatf("v%0d_dma_rdata", v), dma_rdata_o, vecs[v].mem_rdata);
        end
        idle_cycle();

        // Both requesting from idle: 8 CPU, 8 DMA, 8 CPU
        for (int i = 0; i < 24; i++) begin
            @(posedge clk_i); #1;
            drive(1, 4'hF, 24'h001000 + 24'(i), 32'h0, 1, 4'hF, 24'h002000 + 24'(i), 32'h0, 32'h0);
            @(negedge clk_i);
            chk($sformatf("burst%0d_cpu_gnt", i), {31'd0, cpu_gnt_o}, {31'd0, (i < 8) || (i >= 16)});
            chk($sformatf("burst%0d_dma_gnt", i), {31'd0, dma_gnt_o}, {31'd0, (i >= 8) && (i < 16)});
        end
        idle_cycle();

        // DMA alone: 3 reads bring cnt to 3, then 20 more back-to-back reads
        for (int i = 0; i < 23; i++) begin
            @(posedge clk_i); #1;
            drive(0, 4'h0, 24'h0, 32'h0, 1, 4'h0, 24'h003000 + 24'(i), 32'h0, 32'hD0000000 + i);
            @(negedge clk_i);
            chk($sformatf("dsat%0d_dma_gnt", i), {31'd0, dma_gnt_o}, 32'd1);
            chk($sformatf("dsat%0d_dma_rvalid", i), {31'd0, dma_rvalid_o}, {31'd0, i >= 1});
            chk($sformatf("dsat%0d_cpu_rvalid", i), {31'd0, cpu_rvalid_o}, 32'd0);
            if (i >= 1) chk($sformatf("dsat%0d_dma_rdata", i), dma_rdata_o, 32'hD0000000 + i);
        end
        // Saturated DMA burst: contention now hands the port to the CPU
        @(posedge clk_i); #1;
        drive(1, 4'hF, 24'h004000, 32'h0, 1, 4'hF, 24'h005000, 32'h0, 32'hD0000017);
        @(negedge clk_i);
        chk("dsat_end_cpu_gnt", {31'd0, cpu_gnt_o}, 32'd1);
        chk("dsat_end_dma_gnt", {31'd0, dma_gnt_o}, 32'd0);
        chk("dsat_end_dma_rvalid", {31'd0, dma_rvalid_o}, 32'd1);
        idle_cycle();

        // Reset between CPU read issue and response drops the response
        @(posedge clk_i); #1;
        drive(1, 4'h0, 24'h000100, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        chk("rdrop_cpu_gnt", {31'd0, cpu_gnt_o}, 32'd1);
        cpu_req_i = 1'b0;
        rst_ni    = 1'b0;
        @(posedge clk_i); #1;
        mem_data_i = 32'hDEADBEEF;
        chk("rdrop_rvalid_in_rst", {31'd0, cpu_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rdrop_rvalid_after", {31'd0, cpu_rvalid_o}, 32'd0);

        // Asynchronous reset clears a live response immediately
        @(posedge clk_i); #1;
        drive(1, 4'h0, 24'h000104, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        chk("async_rvalid_before", {31'd0, cpu_rvalid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_rvalid_cleared", {31'd0, cpu_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // DMA owning, reset, then CPU wins the first contention
        @(posedge clk_i); #1;
        drive(0, 4'h0, 24'h0, 32'h0, 1, 4'hF, 24'h000060, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        drive(1, 4'hF, 24'h000070, 32'h0, 1, 4'hF, 24'h000064, 32'h0, 32'h0);
        #1;
        chk("own_dma_keeps", {31'd0, dma_gnt_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_cpu_first_gnt", {31'd0, cpu_gnt_o}, 32'd1);
        chk("rst_cpu_first_dma", {31'd0, dma_gnt_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_cpu_gnt", {31'd0, cpu_gnt_o}, 32'd1);
        chk("post_rst_addr", {8'd0, mem_addr_o}, 32'h000070);
        @(posedge clk_i); #1;
        chk("post_rst_cpu_cont", {31'd0, cpu_gnt_o}, 32'd1);
        drive(0, 4'h0, 24'h0, 32'h0, 0, 4'h0, 24'h0, 32'h0, 32'h0);

        @(posedge clk_i); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
